// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate truth-table sequencer: gate-select
// encodings, FSM state codes and tick/width helpers.
package gate_seq_pkg;

  // Gate select encodings as seen on the 3-bit select input.
  typedef enum logic [2:0] {
    SEL_AND   = 3'b000,
    SEL_OR    = 3'b001,
    SEL_NAND  = 3'b010,
    SEL_NOR   = 3'b011,
    SEL_XOR   = 3'b100,
    SEL_XNOR  = 3'b101,
    SEL_NOT_A = 3'b110,
    SEL_BUF_A = 3'b111
  } gate_sel_e;

  // Sequencer states; code 2'b11 is unused and recovers to manual.
  typedef enum logic [1:0] {
    ST_MANUAL    = 2'b00,
    ST_AUTO_RUN  = 2'b01,
    ST_AUTO_STEP = 2'b10
  } seq_state_e;

  localparam int unsigned MS_PER_S = 32'd1000;

  // Convert a duration in ms into clock cycles.
  function automatic int unsigned ms_to_ticks(input int unsigned clk_hz,
                                              input int unsigned ms);
    return (clk_hz / MS_PER_S) * ms;
  endfunction

  // Counter width able to hold 0 .. ticks-1 (at least one bit).
  function automatic int unsigned counter_width(input int unsigned ticks);
    return (ticks > 32'd1) ? $clog2(ticks) : 32'd1;
  endfunction

  // Combinational gate evaluation for a given select and operands.
  function automatic logic gate_eval(input logic [2:0] sel,
                                     input logic       a,
                                     input logic       b);
    logic y;
    case (sel)
      SEL_AND:   y = a & b;
      SEL_OR:    y = a | b;
      SEL_NAND:  y = ~(a & b);
      SEL_NOR:   y = ~(a | b);
      SEL_XOR:   y = a ^ b;
      SEL_XNOR:  y = ~(a ^ b);
      SEL_NOT_A: y = ~a;
      SEL_BUF_A: y = a;
      default:   y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One-bit switch conditioner: two-flop synchronizer followed by a
// counter filter that only accepts a new level after it has been
// stable for TICKS consecutive cycles.
module switch_debounce
  import gate_seq_pkg::*;
#(
  parameter int unsigned TICKS = 32'd2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic dout_o
);

  localparam int unsigned CNT_W = counter_width(TICKS);

  logic             sync1_q;
  logic             sync2_q;
  logic             dout_q;
  logic [CNT_W-1:0] cnt_q;

  // Bring the raw switch level into the clock domain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles of disagreement; adopt the new level when the count completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_q <= 1'b0;
      cnt_q  <= '0;
    end else if (sync2_q == dout_q) begin
      cnt_q  <= '0;
    end else if (cnt_q == CNT_W'(TICKS - 32'd1)) begin
      dout_q <= sync2_q;
      cnt_q  <= '0;
    end else begin
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/gate_truth_table_sequencer.sv
// Gate truth-table sequencer: shows a selectable 2-input gate driven either
// by manual switches or by an automatic 00,01,10,11 pattern sequence that
// can be paused and single-stepped.
// Build option: define GATE_SEQ_DEBOUNCE_EN to filter A, B, MODE, PAUSE and
// STEP through switch_debounce; otherwise only the 2-flop synchronizers are used.
module gate_truth_table_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 32'd100000000,
  parameter int unsigned STEP_MS     = 32'd1000,
  parameter int unsigned DEBOUNCE_MS = 32'd10
) (
  input  logic       I_P_CLK,
  input  logic       I_P_RST,
  input  logic       I_P_A,
  input  logic       I_P_B,
  input  logic       I_P_MODE,
  input  logic       I_P_PAUSE,
  input  logic       I_P_STEP,
  input  logic [2:0] I_P_SEL,
  output logic       O_P_LED_A,
  output logic       O_P_LED_B,
  output logic       O_P_LED_GATE,
  output logic [1:0] O_P_LED_STATE,
  output logic       O_P_LED_WRAP
);

  localparam int unsigned STEP_TICKS = ms_to_ticks(CLK_HZ, STEP_MS);
  localparam int unsigned TIMER_W    = counter_width(STEP_TICKS);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STEP_TICKS - 32'd1);

  // Conditioned control/switch levels.
  logic a_f;
  logic b_f;
  logic mode_f;
  logic pause_f;
  logic step_f;

  // Gate select is only synchronized, never debounced.
  logic [2:0] sel_s1_q;
  logic [2:0] sel_s2_q;

  // Synchronize the gate select bus.
  always_ff @(posedge I_P_CLK) begin
    if (I_P_RST) begin
      sel_s1_q <= 3'b000;
      sel_s2_q <= 3'b000;
    end else begin
      sel_s1_q <= I_P_SEL;
      sel_s2_q <= sel_s1_q;
    end
  end

`ifdef GATE_SEQ_DEBOUNCE_EN
  localparam int unsigned DEBOUNCE_TICKS = ms_to_ticks(CLK_HZ, DEBOUNCE_MS);

  switch_debounce #(.TICKS(DEBOUNCE_TICKS)) u_db_a (
    .clk_i(I_P_CLK), .rst_i(I_P_RST), .din_i(I_P_A), .dout_o(a_f));
  switch_debounce #(.TICKS(DEBOUNCE_TICKS)) u_db_b (
    .clk_i(I_P_CLK), .rst_i(I_P_RST), .din_i(I_P_B), .dout_o(b_f));
  switch_debounce #(.TICKS(DEBOUNCE_TICKS)) u_db_mode (
    .clk_i(I_P_CLK), .rst_i(I_P_RST), .din_i(I_P_MODE), .dout_o(mode_f));
  switch_debounce #(.TICKS(DEBOUNCE_TICKS)) u_db_pause (
    .clk_i(I_P_CLK), .rst_i(I_P_RST), .din_i(I_P_PAUSE), .dout_o(pause_f));
  switch_debounce #(.TICKS(DEBOUNCE_TICKS)) u_db_step (
    .clk_i(I_P_CLK), .rst_i(I_P_RST), .din_i(I_P_STEP), .dout_o(step_f));
`else
  logic [4:0] sw_s1_q;
  logic [4:0] sw_s2_q;

  // Synchronize the switch and button levels (no filtering in this build).
  always_ff @(posedge I_P_CLK) begin
    if (I_P_RST) begin
      sw_s1_q <= 5'b00000;
      sw_s2_q <= 5'b00000;
    end else begin
      sw_s1_q <= {I_P_A, I_P_B, I_P_MODE, I_P_PAUSE, I_P_STEP};
      sw_s2_q <= sw_s1_q;
    end
  end

  assign {a_f, b_f, mode_f, pause_f, step_f} = sw_s2_q;
`endif

  seq_state_e         state_q;
  seq_state_e         state_d;
  logic [1:0]         pattern_q;
  logic [1:0]         pattern_d;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;
  logic               step_prev_q;
  logic               step_rise_s;
  logic               wrap_s;

  logic               led_a_q;
  logic               led_b_q;
  logic               led_gate_q;
  logic               led_wrap_q;

  // A held button yields a single rising edge.
  assign step_rise_s = step_f & ~step_prev_q;

  // State, pattern, dwell timer and step-edge history.
  always_ff @(posedge I_P_CLK) begin
    if (I_P_RST) begin
      state_q     <= ST_MANUAL;
      pattern_q   <= 2'b00;
      timer_q     <= '0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      timer_q     <= timer_d;
      step_prev_q <= step_f;
    end
  end

  // Next-state, pattern and timer logic; the timer only runs in AUTO_RUN.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    timer_d   = '0;
    wrap_s    = 1'b0;
    case (state_q)
      ST_MANUAL: begin
        if (mode_f) begin
          state_d   = pause_f ? ST_AUTO_STEP : ST_AUTO_RUN;
          pattern_d = 2'b00;
        end else begin
          pattern_d = {a_f, b_f};
        end
      end
      ST_AUTO_RUN: begin
        if (!mode_f) begin
          state_d   = ST_MANUAL;
          pattern_d = {a_f, b_f};
        end else if (pause_f) begin
          state_d   = ST_AUTO_STEP;
        end else if (timer_q == TIMER_LAST) begin
          pattern_d = pattern_q + 2'b01;
          wrap_s    = (pattern_q == 2'b11);
        end else begin
          timer_d   = timer_q + TIMER_W'(1);
        end
      end
      ST_AUTO_STEP: begin
        if (!mode_f) begin
          state_d   = ST_MANUAL;
          pattern_d = {a_f, b_f};
        end else if (!pause_f) begin
          // Leaving pause takes priority; a coincident step edge is dropped.
          state_d   = ST_AUTO_RUN;
        end else if (step_rise_s) begin
          pattern_d = pattern_q + 2'b01;
          wrap_s    = (pattern_q == 2'b11);
        end else begin
          pattern_d = pattern_q;
        end
      end
      default: begin
        state_d   = ST_MANUAL;
        pattern_d = 2'b00;
      end
    endcase
  end

  // Register displayed A/B, gate result and wrap pulse together so they stay coherent.
  always_ff @(posedge I_P_CLK) begin
    if (I_P_RST) begin
      led_a_q    <= 1'b0;
      led_b_q    <= 1'b0;
      led_gate_q <= 1'b0;
      led_wrap_q <= 1'b0;
    end else begin
      led_a_q    <= pattern_d[1];
      led_b_q    <= pattern_d[0];
      led_gate_q <= gate_eval(sel_s2_q, pattern_d[1], pattern_d[0]);
      led_wrap_q <= wrap_s;
    end
  end

  assign O_P_LED_A     = led_a_q;
  assign O_P_LED_B     = led_b_q;
  assign O_P_LED_GATE  = led_gate_q;
  assign O_P_LED_STATE = state_q;
  assign O_P_LED_WRAP  = led_wrap_q;

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Directed, table-driven bench for gate_truth_table_sequencer.
module tb_gate_truth_table_sequencer;

  logic       clk;
  logic       rst;
  logic       a;
  logic       b;
  logic       mode;
  logic       pause;
  logic       step;
  logic [2:0] sel;
  logic       led_a;
  logic       led_b;
  logic       led_gate;
  logic [1:0] led_state;
  logic       led_wrap;

  int n_vec = 0;
  int n_err = 0;

  gate_truth_table_sequencer #(
    .CLK_HZ(1000), .STEP_MS(4), .DEBOUNCE_MS(2)
  ) dut (
    .I_P_CLK(clk), .I_P_RST(rst), .I_P_A(a), .I_P_B(b), .I_P_MODE(mode),
    .I_P_PAUSE(pause), .I_P_STEP(step), .I_P_SEL(sel),
    .O_P_LED_A(led_a), .O_P_LED_B(led_b), .O_P_LED_GATE(led_gate),
    .O_P_LED_STATE(led_state), .O_P_LED_WRAP(led_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] sel;
    logic       a;
    logic       b;
    logic       gate;
  } vec_t;

  vec_t vecs[18];

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, input string name);
    for (int i = 0; i < budget && led_state !== st; i++) tick(1);
    check(name, {6'd0, led_state}, {6'd0, st});
  endtask

  task automatic press_step(input int hold, input int rel);
    step = 1'b1;
    tick(hold);
    step = 1'b0;
    tick(rel);
  endtask

  initial begin
    int wraps;
    // {sel, a, b, expected gate}
    vecs[0]  = '{3'b000, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{3'b001, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{3'b010, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{3'b011, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{3'b100, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{3'b101, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{3'b110, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{3'b111, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{3'b001, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b100, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{3'b100, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{3'b010, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{3'b011, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{3'b110, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{3'b111, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{3'b000, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{3'b101, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{3'b011, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; a = 1'b0; b = 1'b0; mode = 1'b0; pause = 1'b0; step = 1'b0; sel = 3'b010;
    tick(3);
    // Reset state: every output 0, GATE not the NAND value.
    check("reset_outputs", {3'd0, led_a, led_b, led_gate, led_state},  8'h00);
    check("reset_wrap", {7'd0, led_wrap}, 8'h00);
    rst = 1'b0;

    // Manual mode gate table.
    for (int i = 0; i < 18; i++) begin
      sel = vecs[i].sel; a = vecs[i].a; b = vecs[i].b;
      tick(8);
      check($sformatf("manual_vec%0d", i),
            {3'd0, led_a, led_b, led_gate, led_state},
            {3'd0, vecs[i].a, vecs[i].b, vecs[i].gate, 2'b00});
    end

    // Auto run with NAND: 00,01,10,11,00 every 4 cycles, one wrap pulse.
    a = 1'b0; b = 1'b0; sel = 3'b010; pause = 1'b0; mode = 1'b0;
    rst = 1'b1; tick(1); rst = 1'b0;
    mode = 1'b1;
    wait_state(2'b01, 20, "enter_auto_run");
    for (int n = 0; n < 20; n++) begin
      logic [1:0] p;
      p = 2'((n / 4) % 4);
      check($sformatf("auto_run_n%0d", n),
            {4'd0, led_a, led_b, led_gate, led_wrap},
            {4'd0, p[1], p[0], ~(p[1] & p[0]), (n == 16) ? 1'b1 : 1'b0});
      tick(1);
    end

    // Reset mid-sequence at pattern 10.
    for (int i = 0; i < 12 && {led_a, led_b} !== 2'b10; i++) tick(1);
    check("auto_at_10", {6'd0, led_a, led_b}, 8'h02);
    rst = 1'b1; tick(1);
    check("rst_mid_outputs", {2'd0, led_a, led_b, led_gate, led_wrap, led_state}, 8'h00);
    rst = 1'b0; tick(1);
    check("rst_first_cycle", {3'd0, led_a, led_b, led_wrap, led_state}, 8'h00);

    // Paused auto mode: stepping, held button, stepped wrap.
    mode = 1'b0; pause = 1'b1;
    wait_state(2'b00, 20, "back_to_manual");
    tick(6);
    mode = 1'b1;
    wait_state(2'b10, 20, "enter_auto_step");
    check("step_start", {6'd0, led_a, led_b}, 8'h00);
    press_step(5, 6);
    check("step_to_01", {6'd0, led_a, led_b}, 8'h01);
    press_step(10, 6);
    check("held_step_to_10", {6'd0, led_a, led_b}, 8'h02);
    press_step(5, 6);
    check("step_to_11", {6'd0, led_a, led_b}, 8'h03);
    wraps = 0;
    step = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (i == 5) step = 1'b0;
      if (led_wrap === 1'b1) wraps++;
    end
    check("step_wrap_count", 8'(wraps), 8'h01);
    check("step_wrap_pattern", {4'd0, led_a, led_b, led_state}, 8'h02);

    // Select change in paused auto leaves pattern alone and updates GATE.
    sel = 3'b110;
    tick(6);
    check("sel_change_paused", {3'd0, led_a, led_b, led_gate, led_state}, 8'h06);

    // Mode low forces manual; LEDs follow switches.
    a = 1'b1; b = 1'b0; sel = 3'b001; mode = 1'b0;
    wait_state(2'b00, 20, "mode_low_manual");
    tick(2);
    check("manual_follow", {5'd0, led_a, led_b, led_gate}, 8'h05);

`ifdef GATE_SEQ_DEBOUNCE_EN
    // Debounce: a 1-cycle glitch on A is rejected, a stable level is accepted.
    a = 1'b0; b = 1'b0; sel = 3'b111;
    tick(8);
    a = 1'b1; tick(1); a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check($sformatf("glitch_n%0d", i), {7'd0, led_a}, 8'h00);
    end
    a = 1'b1;
    tick(8);
    check("stable_a", {6'd0, led_a, led_gate}, 8'h03);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gate_truth_table_sequencer.md
GATE_TRUTH_TABLE_SEQUENCER -- requirements
Module: gate_truth_table_sequencer

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter STEP_MS, default 1000, auto-mode dwell time per input pattern in ms.
REQ-003 Parameter DEBOUNCE_MS, default 10, required stable time for switch/button inputs in ms.
REQ-004 I_P_CLK  in  1  single system clock; all logic is rising-edge on this clock.
REQ-005 I_P_RST  in  1  reset; synchronous and active-high.
REQ-006 I_P_A  in  1  manual gate input A (switch).
REQ-007 I_P_B  in  1  manual gate input B (switch).
REQ-008 I_P_MODE  in  1  0 = manual, 1 = automatic truth-table sequencing.
REQ-009 I_P_PAUSE  in  1  1 = hold the auto sequence and enable single-stepping.
REQ-010 I_P_STEP  in  1  step button; one press advances one pattern while paused.
REQ-011 I_P_SEL  in  3  gate select: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 NOT A, 111 BUF A.
REQ-012 O_P_LED_A / O_P_LED_B  out  1 each  gate input currently applied.
REQ-013 O_P_LED_GATE  out  1  gate result for the displayed A/B and I_P_SEL.
REQ-014 O_P_LED_STATE  out  2  current FSM state code.
REQ-015 O_P_LED_WRAP  out  1  one-cycle pulse when the auto pattern wraps 11 -> 00.

Function
REQ-016 All async inputs pass through a 2-flop synchronizer before any use.
REQ-017 FSM states/codes: MANUAL 00, AUTO_RUN 01, AUTO_STEP 10; code 11 unused and recovers to MANUAL next cycle.
REQ-018 Synced MODE=0 forces MANUAL from any state in the next cycle.
REQ-019 MANUAL -> AUTO_RUN on MODE=1 with PAUSE=0; MANUAL -> AUTO_STEP on MODE=1 with PAUSE=1; on either entry pattern = 00, dwell timer = 0.
REQ-020 AUTO_RUN -> AUTO_STEP on PAUSE=1, pattern held, timer cleared; AUTO_STEP -> AUTO_RUN on PAUSE=0, timer restarts from 0.
REQ-021 In MANUAL, pattern {A,B} = debounced switch values.
REQ-022 In AUTO_RUN, pattern {A,B} increments 00,01,10,11 after exactly STEP_TICKS = CLK_HZ/1000*STEP_MS cycles, wrapping 11 -> 00.
REQ-023 In AUTO_STEP, each debounced STEP rising edge increments the pattern once; held button gives one step only.
REQ-024 O_P_LED_WRAP pulses one cycle on every 11 -> 00 transition (timed or stepped), never in MANUAL.
REQ-025 O_P_LED_A, O_P_LED_B, O_P_LED_GATE are registered together: GATE always matches A/B/SEL displayed in the same cycle.
REQ-026 Changing SEL updates GATE one cycle after the synced SEL changes, without disturbing pattern or timer.
REQ-027 Simultaneous STEP edge and PAUSE fall: the state change wins, step is discarded.
REQ-028 Dwell timer width = clog2(STEP_TICKS); it never overflows or free-runs outside AUTO_RUN.

Reset
REQ-029 On I_P_RST=1 at a clock edge: state MANUAL, pattern 00, timer 0, synchronizer and debounce state 0, all outputs 0 (GATE 0, not the NAND value).
REQ-030 Reset mid-sequence discards the pattern; first post-reset cycle shows A=B=0, GATE evaluated from cycle 2.

Configuration
REQ-031 Macro GATE_SEQ_DEBOUNCE_EN defined: A, B, MODE, PAUSE, STEP filtered by debouncers of DEBOUNCE_TICKS = CLK_HZ/1000*DEBOUNCE_MS cycles.
REQ-032 Macro undefined: debouncers omitted, synchronizer outputs used directly; DEBOUNCE_MS ignored.

Structure
REQ-033 Shared package gate_seq_pkg holds gate-select encodings, FSM state type/codes and tick-computation constants.
REQ-034 One sub-module, switch_debounce (1-bit sync + counter filter), instantiated per filtered input under GATE_SEQ_DEBOUNCE_EN.

Verification
REQ-035 Sim with CLK_HZ=1000, STEP_MS=4, DEBOUNCE_MS=2, macro both ways.
REQ-036 Reset then MODE=1,PAUSE=0,SEL=010 -> patterns 00,01,10,11,00 every 4 cycles; GATE 1,1,1,0,1; WRAP one pulse at 11->00.
REQ-037 MANUAL, A=1,B=1, SEL sweeps 000..111 -> GATE 1,1,0,0,0,1,0,1.
REQ-038 AUTO, PAUSE=1 at pattern 01; STEP held 10 cycles -> pattern 10 only; second press -> 11.
REQ-039 Macro on: A glitch 1 cycle wide -> LED_A unchanged; A stable 3 cycles -> LED_A=1.
REQ-040 RST asserted in AUTO_RUN at pattern 10 -> next cycle state 00, all outputs 0, timer 0.
